// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmit data channel
// between NREQ byte-stream requesters. A grant is held for a whole packet
// (or MAXBURST bytes), then the block drains the shifter before re-arbitrating
// and keeps the transmitter enabled only while a burst is in progress.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAXBURST = 4
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NREQ-1:0]         reqValid,
    input  logic [NREQ*DW-1:0]      reqData,
    input  logic [NREQ-1:0]         reqLast,
    output logic [NREQ-1:0]         reqRead,
    output logic [DW-1:0]           txData,
    output logic                    txDataReady,
    input  logic                    txDataRead,
    input  logic                    eventReadyTx,
    output logic                    uartTxEnable,
    output logic [$clog2(NREQ)-1:0] grantId,
    output logic                    busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAXBURST);
    localparam logic [GW-1:0] LAST_ID   = GW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [CW-1:0]   burst_q;
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   outst_d;
    logic            busy_q;
    logic            txen_q;

    logic [DW-1:0]   sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            accept;
    logic            evt_ok;
    logic [CW-1:0]   burst_inc;
    logic            arb_hit;
    logic [GW-1:0]   arb_id;
    logic [GW-1:0]   arb_idx;

    // Route the granted requester's byte, valid and last flag to the channel.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data  = reqData[i*DW +: DW];
                sel_valid = reqValid[i];
                sel_last  = reqLast[i];
            end
        end
    end

    assign txDataReady  = (state_q == SEND) && sel_valid;
    assign txData       = (state_q == SEND) ? sel_data : '0;
    assign accept       = txDataReady && txDataRead;
    assign evt_ok       = eventReadyTx && (outst_q != '0);
    assign burst_inc    = burst_q + CW'(1);
    assign uartTxEnable = txen_q;
    assign busy         = busy_q;
    assign grantId      = grant_q;

    // One-hot read strobe back to the granted requester on each accepted byte.
    always_comb begin
        reqRead = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqRead[i] = accept && (grant_q == GW'(i));
        end
    end

    // Rotating priority search starting just after the last granted requester.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = grant_q;
        arb_idx = grant_q;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = (arb_idx == LAST_ID) ? '0 : arb_idx + GW'(1);
            if (!arb_hit && reqValid[arb_idx]) begin
                arb_hit = 1'b1;
                arb_id  = arb_idx;
            end
        end
    end

    // Bytes accepted but not yet shifted out; simultaneous accept and
    // completion cancel, completions with nothing pending are dropped.
    always_comb begin
        outst_d = outst_q;
        if (accept && !evt_ok) begin
            if (outst_q != BURST_MAX) begin
                outst_d = outst_q + CW'(1);
            end
        end else if (evt_ok && !accept) begin
            outst_d = outst_q - CW'(1);
        end
    end

    // Grant/burst/drain sequencing with registered busy and transmitter enable.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= LAST_ID;
            burst_q <= '0;
            outst_q <= '0;
            busy_q  <= 1'b0;
            txen_q  <= 1'b0;
        end else begin
            outst_q <= outst_d;
            case (state_q)
                IDLE: begin
                    if (enable && arb_hit) begin
                        grant_q <= arb_id;
                        burst_q <= '0;
                        state_q <= SEND;
                        busy_q  <= 1'b1;
                        txen_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        burst_q <= burst_inc;
                        if (sel_last || (burst_inc == BURST_MAX)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (outst_d == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        txen_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    txen_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester byte buffers and a UART model drive
// the DUT; every byte taken from a requester is checked against a scoreboard
// of expected (requester, byte) pairs filled when the stimulus is queued.
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 8;
    localparam int MAXBURST = 4;
    localparam int SHIFT    = 3;

    logic                 ck;
    logic                 rst;
    logic                 enable;
    logic [NREQ-1:0]      reqValid;
    logic [NREQ*DW-1:0]   reqData;
    logic [NREQ-1:0]      reqLast;
    logic [NREQ-1:0]      reqRead;
    logic [DW-1:0]        txData;
    logic                 txDataReady;
    logic                 txDataRead;
    logic                 eventReadyTx;
    logic                 uartTxEnable;
    logic [1:0]           grantId;
    logic                 busy;

    uart_tx_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .MAXBURST (MAXBURST)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .enable       (enable),
        .reqValid     (reqValid),
        .reqData      (reqData),
        .reqLast      (reqLast),
        .reqRead      (reqRead),
        .txData       (txData),
        .txDataReady  (txDataReady),
        .txDataRead   (txDataRead),
        .eventReadyTx (eventReadyTx),
        .uartTxEnable (uartTxEnable),
        .grantId      (grantId),
        .busy         (busy)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t            exp_q[$];
    logic [8:0]      rbuf [NREQ][16];
    logic [3:0]      rhead [NREQ];
    logic [3:0]      rtail [NREQ];
    logic [NREQ-1:0] pop_pend;
    logic [NREQ-1:0] hold;
    logic            uart_auto;
    logic            man_read;
    logic            man_evt;
    int              pend;
    int              tmr;
    int              n_chk;
    int              n_pass;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        rbuf[r][rtail[r]] = {last, d};
        rtail[r] = rtail[r] + 4'd1;
    endtask

    task automatic expect_b(input int r, input logic [7:0] d);
        exp_t x;
        x.id   = 2'(r);
        x.data = d;
        exp_q.push_back(x);
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (rhead[i] != rtail[i]) e = 1'b0;
        end
        return e;
    endfunction

    // One clock cycle: retire bytes taken at this edge, drive requesters and
    // the UART model, then sample outputs mid-cycle against the scoreboard.
    task automatic tick();
        logic [8:0] e;
        exp_t       x;
        @(posedge ck);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (pop_pend[i]) rhead[i] = rhead[i] + 4'd1;
        end
        pop_pend = '0;
        if (uart_auto) begin
            eventReadyTx = 1'b0;
            if (pend > 0) begin
                if (tmr == SHIFT - 1) begin
                    eventReadyTx = 1'b1;
                    pend--;
                    tmr = 0;
                end else begin
                    tmr++;
                end
            end
        end else begin
            eventReadyTx = man_evt;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rhead[i] != rtail[i]) begin
                e = rbuf[i][rhead[i]];
                reqValid[i]          = ~hold[i];
                reqData[i*DW +: DW]  = e[7:0];
                reqLast[i]           = e[8];
            end else begin
                reqValid[i]          = 1'b0;
                reqData[i*DW +: DW]  = '0;
                reqLast[i]           = 1'b0;
            end
        end
        #1;
        txDataRead = uart_auto ? txDataReady : man_read;
        #1;
        if (reqRead != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_read", 32'(reqRead), 32'd0);
            end else begin
                x = exp_q.pop_front();
                check_eq("sb_id", 32'(reqRead), 32'd1 << x.id);
                check_eq("sb_data", 32'(txData), 32'(x.data));
            end
            pop_pend = reqRead;
            if (uart_auto) pend++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rhead[i] = '0;
            rtail[i] = '0;
        end
        exp_q.delete();
        pop_pend = '0;
        hold     = '0;
        man_read = 1'b0;
        man_evt  = 1'b0;
        pend     = 0;
        tmr      = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = queues_empty() && !busy && (pend == 0);
        end
        check_eq(tag, 32'(done), 32'd1);
        check_eq({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        enable = 1'b1;
        reqValid = '0;
        reqData = '0;
        reqLast = '0;
        txDataRead = 1'b0;
        eventReadyTx = 1'b0;
        uart_auto = 1'b0;

        // Reset values
        do_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rdy", 32'(txDataReady), 32'd0);
        check_eq("rst_txdata", 32'(txData), 32'd0);
        check_eq("rst_reqread", 32'(reqRead), 32'd0);
        check_eq("rst_txen", 32'(uartTxEnable), 32'd0);
        check_eq("rst_gid", 32'(grantId), 32'd3);

        // Single requester, two-byte packet, manual UART handshakes
        uart_auto = 1'b0;
        push_byte(2, 8'h55, 1'b0); push_byte(2, 8'hAA, 1'b1);
        expect_b(2, 8'h55); expect_b(2, 8'hAA);
        tick();
        check_eq("t1_rdy_before_grant", 32'(txDataReady), 32'd0);
        man_read = 1'b1;
        tick();
        check_eq("t1_gid", 32'(grantId), 32'd2);
        check_eq("t1_rdy", 32'(txDataReady), 32'd1);
        check_eq("t1_read0", 32'(reqRead), 32'h4);
        tick();
        check_eq("t1_read1", 32'(reqRead), 32'h4);
        man_read = 1'b0; man_evt = 1'b1;
        tick();
        check_eq("t1_drain_rdy", 32'(txDataReady), 32'd0);
        check_eq("t1_drain_busy", 32'(busy), 32'd1);
        tick();
        check_eq("t1_drain_txen", 32'(uartTxEnable), 32'd1);
        man_evt = 1'b0;
        tick();
        check_eq("t1_idle_busy", 32'(busy), 32'd0);
        check_eq("t1_idle_txen", 32'(uartTxEnable), 32'd0);
        check_eq("t1_idle_gid", 32'(grantId), 32'd2);
        check_eq("t1_sb_left", 32'(exp_q.size()), 32'd0);

        // Round-robin fairness with single-byte packets
        do_reset();
        uart_auto = 1'b1;
        for (int r = 0; r < NREQ; r++) push_byte(r, 8'h10 + 8'(r), 1'b1);
        for (int r = 0; r < NREQ; r++) push_byte(r, 8'h20 + 8'(r), 1'b1);
        for (int r = 0; r < NREQ; r++) expect_b(r, 8'h10 + 8'(r));
        for (int r = 0; r < NREQ; r++) expect_b(r, 8'h20 + 8'(r));
        wait_done("rr_done", 300);
        check_eq("rr_last_gid", 32'(grantId), 32'd3);

        // MAXBURST forced rotation
        do_reset();
        uart_auto = 1'b1;
        for (int b = 1; b <= 10; b++) push_byte(1, 8'(b), (b == 10));
        push_byte(3, 8'hC3, 1'b1);
        for (int b = 1; b <= 4; b++) expect_b(1, 8'(b));
        expect_b(3, 8'hC3);
        for (int b = 5; b <= 10; b++) expect_b(1, 8'(b));
        wait_done("burst_done", 400);
        check_eq("burst_last_gid", 32'(grantId), 32'd1);

        // Packet lock while the granted requester stalls
        do_reset();
        uart_auto = 1'b1;
        push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h3C, 1'b1);
        push_byte(1, 8'h77, 1'b1);
        expect_b(0, 8'h11); expect_b(0, 8'h3C); expect_b(1, 8'h77);
        tick();
        tick();
        hold[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("lock_gid", 32'(grantId), 32'd0);
            check_eq("lock_rdy", 32'(txDataReady), 32'd0);
        end
        hold[0] = 1'b0;
        wait_done("lock_done", 200);

        // Spurious events and simultaneous accept/completion
        do_reset();
        uart_auto = 1'b0;
        man_evt = 1'b1;
        tick();
        check_eq("spur_evt_busy", 32'(busy), 32'd0);
        man_evt = 1'b0; man_read = 1'b1;
        tick();
        check_eq("spur_read", 32'(reqRead), 32'd0);
        check_eq("spur_read_busy", 32'(busy), 32'd0);
        man_read = 1'b0;
        push_byte(2, 8'hA1, 1'b0); push_byte(2, 8'hA2, 1'b0); push_byte(2, 8'hA3, 1'b1);
        expect_b(2, 8'hA1); expect_b(2, 8'hA2); expect_b(2, 8'hA3);
        tick();
        man_read = 1'b1;
        tick();
        man_evt = 1'b1;
        tick();
        man_evt = 1'b0;
        tick();
        man_read = 1'b0; man_evt = 1'b1;
        tick();
        check_eq("sim_drain1", 32'(busy), 32'd1);
        tick();
        check_eq("sim_drain2", 32'(busy), 32'd1);
        man_evt = 1'b0;
        tick();
        check_eq("sim_idle", 32'(busy), 32'd0);
        check_eq("sim_sb_left", 32'(exp_q.size()), 32'd0);

        // enable low in IDLE blocks grants; raising it serves everyone
        do_reset();
        uart_auto = 1'b1;
        enable = 1'b0;
        for (int r = 0; r < NREQ; r++) push_byte(r, 8'h40 + 8'(r), 1'b1);
        for (int k = 0; k < 4; k++) tick();
        check_eq("en_off_busy", 32'(busy), 32'd0);
        check_eq("en_off_rdy", 32'(txDataReady), 32'd0);
        check_eq("en_off_gid", 32'(grantId), 32'd3);
        enable = 1'b1;
        for (int r = 0; r < NREQ; r++) expect_b(r, 8'h40 + 8'(r));
        wait_done("en_on_done", 300);

        // enable dropped mid-SEND: packet completes, then block parks in IDLE
        do_reset();
        uart_auto = 1'b1;
        push_byte(0, 8'h51, 1'b0); push_byte(0, 8'h52, 1'b0); push_byte(0, 8'h53, 1'b1);
        push_byte(1, 8'h61, 1'b1);
        expect_b(0, 8'h51); expect_b(0, 8'h52); expect_b(0, 8'h53);
        tick();
        tick();
        enable = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check_eq("en_drop_idle", 32'(busy), 32'd0);
        check_eq("en_drop_pending", 32'(rtail[1] - rhead[1]), 32'd1);
        check_eq("en_drop_sb_left", 32'(exp_q.size()), 32'd0);
        enable = 1'b1;
        expect_b(1, 8'h61);
        wait_done("en_drop_resume", 200);

        // Reset mid-SEND
        do_reset();
        uart_auto = 1'b0;
        push_byte(1, 8'h71, 1'b0); push_byte(1, 8'h72, 1'b1);
        tick();
        tick();
        check_eq("rst_pre_rdy", 32'(txDataReady), 32'd1);
        check_eq("rst_pre_gid", 32'(grantId), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("rst_mid_rdy", 32'(txDataReady), 32'd0);
        check_eq("rst_mid_txen", 32'(uartTxEnable), 32'd0);
        check_eq("rst_mid_gid", 32'(grantId), 32'd3);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
